// File: rtl/nn_mem_pkg.sv
// nn_mem_pkg: shared image-memory types and sizing for writer and reader
package nn_mem_pkg;
  localparam int IN_WIDTH = 784;
  typedef logic [31:0] word_t;
  typedef enum logic {FILL, DROP} wr_state_e;
endpackage

// File: rtl/image_mem_writer_slot_occupancy.sv
// slot_occupancy: counts committed, unreleased ring slots and flags a full ring
module slot_occupancy #(
  parameter int NUM_IMAGES = 4,
  localparam int UW = $clog2(NUM_IMAGES + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          commit,
  input  logic          rel,
  output logic [UW-1:0] used,
  output logic          full
);
  logic [UW-1:0] used_q, used_d;
  // a release is only honoured when a slot is held; commit and release cancel
  always_comb used_d = used_q + UW'(commit) - UW'(rel && used_q != '0);
  // occupancy register
  always_ff @(posedge clk)
    if (rst) used_q <= '0;
    else used_q <= used_d;
  assign used = used_q;
  assign full = used_q == UW'(NUM_IMAGES);
endmodule

// File: rtl/image_mem_writer.sv
// image_mem_writer: streams framed pixel words into a ring of image slots
module image_mem_writer
  import nn_mem_pkg::*;
#(
  parameter int IN_WIDTH = nn_mem_pkg::IN_WIDTH,
  parameter int NUM_IMAGES = 4,
  localparam int UW = $clog2(NUM_IMAGES + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [31:0]   s_data,
  input  logic          s_last,
  output logic          mem_we,
  output logic [31:0]   mem_addr,
  output logic [31:0]   mem_wdata,
  output logic          img_done,
  output logic [31:0]   img_base,
  input  logic          rel,
  output logic [UW-1:0] used,
  output logic          err_short,
  output logic          err_long
);
  localparam int IW = $clog2(IN_WIDTH);
  localparam int SW = NUM_IMAGES > 1 ? $clog2(NUM_IMAGES) : 1;
  wr_state_e state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [SW-1:0] slot_q, slot_d;
  logic [31:0] base, addr_d, img_base_d;
  word_t wdata_d;
  logic commit, full, xfer, we_d, done_d, es_d, el_d;
  assign base = 32'(slot_q) * 32'(IN_WIDTH);
  assign s_ready = !rst && (state_q == DROP || !full);
  assign xfer = s_valid && s_ready;
  // framing decisions: write, commit, short/long detection and drop recovery
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    slot_d = slot_q;
    commit = 1'b0;
    we_d = 1'b0;
    addr_d = mem_addr;
    wdata_d = mem_wdata;
    done_d = 1'b0;
    img_base_d = img_base;
    es_d = 1'b0;
    el_d = 1'b0;
    if (xfer && state_q == FILL) begin
      we_d = 1'b1;
      addr_d = base + 32'(idx_q);
      wdata_d = s_data;
      if (idx_q == IW'(IN_WIDTH - 1)) begin
        commit = 1'b1;
        done_d = 1'b1;
        img_base_d = base;
        slot_d = slot_q == SW'(NUM_IMAGES - 1) ? '0 : slot_q + SW'(1);
        idx_d = '0;
        el_d = !s_last;
        state_d = s_last ? FILL : DROP;
      end else begin
        es_d = s_last;
        idx_d = s_last ? '0 : idx_q + IW'(1);
      end
    end else if (xfer && s_last) begin
      state_d = FILL;
      idx_d = '0;
    end
  end
  // state and registered write/status outputs
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= FILL;
      idx_q <= '0;
      slot_q <= '0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      img_done <= 1'b0;
      img_base <= '0;
      err_short <= 1'b0;
      err_long <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      slot_q <= slot_d;
      mem_we <= we_d;
      mem_addr <= addr_d;
      mem_wdata <= wdata_d;
      img_done <= done_d;
      img_base <= img_base_d;
      err_short <= es_d;
      err_long <= el_d;
    end
  slot_occupancy #(.NUM_IMAGES(NUM_IMAGES)) u_occ (
    .clk(clk),
    .rst(rst),
    .commit(commit),
    .rel(rel),
    .used(used),
    .full(full)
  );
endmodule

// File: tb/tb_image_mem_writer.sv
// tb_image_mem_writer: randomized and directed checks against a frame-level model
module tb_image_mem_writer;
  localparam int IW = 784;
  localparam int NI = 4;
  logic clk = 0, rst = 1, s_valid = 0, s_last = 0, rel = 0;
  logic [31:0] s_data = 0;
  logic s_ready, mem_we, img_done, err_short, err_long;
  logic [31:0] mem_addr, mem_wdata, img_base;
  logic [2:0] used;
  int checks = 0, failures = 0;
  bit gaps = 1, rand_rel = 0;
  bit m_drop;
  int m_pos, m_slot, m_used;
  bit e_we, e_done, e_es, e_el;
  logic [31:0] e_addr, e_wdata, e_base;

  image_mem_writer #(.IN_WIDTH(IW), .NUM_IMAGES(NI)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .img_done(img_done), .img_base(img_base), .rel(rel), .used(used),
    .err_short(err_short), .err_long(err_long)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", n, a, e, $time);
    end
  endtask

  // one clock: check ready, advance the frame model at the edge, compare outputs
  task automatic cyc(output bit acc);
    bit rdy, com;
    #1;
    rdy = !rst && (m_drop || m_used < NI);
    chk("s_ready", s_ready, rdy);
    acc = s_valid && rdy;
    @(posedge clk);
    if (rst) begin
      m_drop = 0; m_pos = 0; m_slot = 0; m_used = 0;
      e_we = 0; e_addr = 0; e_wdata = 0; e_done = 0; e_base = 0; e_es = 0; e_el = 0;
    end else begin
      com = 0; e_we = 0; e_done = 0; e_es = 0; e_el = 0;
      if (acc && !m_drop) begin
        e_we = 1;
        e_addr = m_slot * IW + m_pos;
        e_wdata = s_data;
        if (m_pos == IW - 1) begin
          com = 1; m_pos = 0;
          if (!s_last) begin e_el = 1; m_drop = 1; end
        end else if (s_last) begin
          e_es = 1; m_pos = 0;
        end else m_pos++;
      end else if (acc && s_last) m_drop = 0;
      if (com) begin
        e_done = 1; e_base = m_slot * IW; m_slot = (m_slot + 1) % NI;
      end
      m_used = m_used + int'(com) - int'(rel && m_used > 0);
    end
    @(negedge clk);
    chk("mem_we", mem_we, e_we);
    if (e_we) begin
      chk("mem_addr", mem_addr, e_addr);
      chk("mem_wdata", mem_wdata, e_wdata);
    end
    chk("img_done", img_done, e_done);
    chk("img_base", img_base, e_base);
    chk("used", used, m_used);
    chk("err_short", err_short, e_es);
    chk("err_long", err_long, e_el);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) cyc(acc);
  endtask

  task automatic send_word(input logic [31:0] d, input bit l, input bit r);
    bit acc;
    int n = 0;
    while (gaps && $urandom_range(3) == 0) begin
      s_valid = 0;
      rel = rand_rel && m_used > 0 && $urandom_range(7) == 0;
      cyc(acc);
    end
    s_valid = 1; s_data = d; s_last = l;
    do begin
      rel = r || (rand_rel && m_used > 0 && $urandom_range(7) == 0);
      cyc(acc);
      n++;
    end while (!acc && n < 3000);
    if (!acc) begin
      checks++; failures++;
      $display("FAIL accept_timeout got=0 exp=1 t=%0t", $time);
    end
    s_valid = 0; s_last = 0; rel = 0;
  endtask

  task automatic send_img(input int len, input bit last_end, input bit seq, input bit rel_last);
    for (int i = 0; i < len; i++)
      send_word(seq ? 32'(i) : $urandom, last_end && i == len - 1, rel_last && i == len - 1);
  endtask

  task automatic reset_vals(input string n);
    chk({n, "_ready"}, s_ready, 0);
    chk({n, "_we"}, mem_we, 0);
    chk({n, "_addr"}, mem_addr, 0);
    chk({n, "_wdata"}, mem_wdata, 0);
    chk({n, "_done"}, img_done, 0);
    chk({n, "_base"}, img_base, 0);
    chk({n, "_used"}, used, 0);
    chk({n, "_es"}, err_short, 0);
    chk({n, "_el"}, err_long, 0);
  endtask

  task automatic do_reset();
    s_valid = 0; rel = 0; rst = 1;
    idle(2);
    reset_vals("lit_rst");
    rst = 0;
  endtask

  initial begin
    bit acc;
    @(negedge clk);
    do_reset();
    send_img(IW, 1, 1, 0);
    chk("lit_norm_done", img_done, 1);
    chk("lit_norm_base", img_base, 0);
    chk("lit_norm_used", used, 1);
    chk("lit_norm_addr", mem_addr, 783);
    chk("lit_norm_data", mem_wdata, 783);
    for (int k = 1; k < NI; k++) begin
      send_img(IW, 1, 0, 0);
      chk("lit_ring_base", img_base, 784 * k);
    end
    chk("lit_ring_used", used, 4);
    s_valid = 1; s_data = 32'hdead; s_last = 1;
    for (int i = 0; i < 4; i++) begin
      cyc(acc);
      chk("lit_stall_ready", s_ready, 0);
      chk("lit_stall_we", mem_we, 0);
    end
    rel = 1;
    cyc(acc);
    rel = 0; s_valid = 0; s_last = 0;
    chk("lit_rel_used", used, 3);
    chk("lit_rel_ready", s_ready, 1);
    send_img(IW, 1, 0, 0);
    chk("lit_fifth_base", img_base, 0);
    chk("lit_fifth_used", used, 4);
    do_reset();
    rel = 1;
    cyc(acc);
    rel = 0;
    chk("lit_rel_empty", used, 0);
    send_img(10, 1, 0, 0);
    chk("lit_short_es", err_short, 1);
    chk("lit_short_done", img_done, 0);
    chk("lit_short_used", used, 0);
    send_img(IW, 1, 1, 0);
    chk("lit_after_short_base", img_base, 0);
    chk("lit_after_short_addr", mem_addr, 783);
    do_reset();
    send_img(IW, 0, 0, 0);
    chk("lit_long_done", img_done, 1);
    chk("lit_long_el", err_long, 1);
    chk("lit_long_base", img_base, 0);
    send_img(3, 1, 0, 0);
    chk("lit_drop_we", mem_we, 0);
    chk("lit_drop_used", used, 1);
    send_img(IW, 1, 0, 0);
    chk("lit_after_long_base", img_base, 784);
    do_reset();
    send_img(IW, 1, 0, 0);
    send_img(IW, 1, 0, 0);
    chk("lit_sim_pre", used, 2);
    send_img(IW, 1, 0, 1);
    chk("lit_sim_used", used, 2);
    chk("lit_sim_done", img_done, 1);
    do_reset();
    send_img(100, 0, 0, 0);
    rst = 1;
    cyc(acc);
    reset_vals("lit_mid_rst");
    rst = 0;
    send_img(IW, 1, 1, 0);
    chk("lit_mid_base", img_base, 0);
    chk("lit_mid_addr", mem_addr, 783);
    chk("lit_mid_used", used, 1);
    do_reset();
    rand_rel = 1;
    for (int f = 0; f < 20; f++) begin
      int kind = $urandom_range(3);
      if (kind == 0) send_img($urandom_range(IW - 1, 1), 1, 0, 0);
      else if (kind == 1) send_img(IW + $urandom_range(5, 1), 1, 0, 0);
      else send_img(IW, 1, 0, 0);
    end
    rand_rel = 0;
    idle(5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
